// File: rtl/issue_queue_param_pkg.sv
// issue_queue_param_pkg: shared defaults and ROB age comparison for the issue queue.
package issue_queue_param_pkg;
    localparam int IQ_ENT_NUM  = 8;
    localparam int MAX_LATENCY = 3;

    // a is younger than b; the sort bit at position w resolves ROB index wrap-around
    function automatic logic rob_younger(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [31:0] m;
        logic [31:0] s;
        s = 32'd1 << w;
        m = s - 32'd1;
        return (((a ^ b) & s) == 32'd0) ? ((a & m) > (b & m)) : ((a & m) < (b & m));
    endfunction
endpackage

// File: rtl/issue_queue_param_age_select.sv
// issue_queue_param_age_select: age matrix + request vector -> per-port one-hot oldest-first grants.
module issue_queue_param_age_select
    import issue_queue_param_pkg::*;
#(
    parameter int ENTRIES = IQ_ENT_NUM,
    parameter int ISS_W   = 2
) (
    input  logic [ENTRIES*ENTRIES-1:0] i_old,
    input  logic [ENTRIES-1:0]         i_req,
    output logic [ISS_W*ENTRIES-1:0]   o_grant
);
    always_comb begin
        logic [ENTRIES-1:0] w_rem;
        logic               w_win;
        o_grant = '0;
        w_rem   = i_req;
        w_win   = 1'b0;
        for (int p = 0; p < ISS_W; p++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                w_win = w_rem[i];
                for (int j = 0; j < ENTRIES; j++)
                    if (j != i && w_rem[j] && !i_old[i*ENTRIES+j]) w_win = 1'b0;
                o_grant[p*ENTRIES+i] = w_win;
            end
            w_rem = w_rem & ~o_grant[p*ENTRIES +: ENTRIES];
        end
    end
endmodule

// File: rtl/issue_queue_param.sv
// issue_queue_param: out-of-order issue queue with wakeup CAM, latency shift registers,
// free-entry allocation, oldest-first multi-port select and mispredict flush.
module issue_queue_param
    import issue_queue_param_pkg::*;
#(
    parameter int ENTRIES = IQ_ENT_NUM,
    parameter int DISP_W  = 2,
    parameter int ISS_W   = 2,
    parameter int BC_W    = 2,
    parameter int TAG_W   = 6,
    parameter int ROB_W   = 6,
    parameter int LAT_W   = MAX_LATENCY + 1,
    parameter int PAY_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DISP_W-1:0]          disp_valid,
    output logic                       disp_ready,
    input  logic [DISP_W*TAG_W-1:0]    disp_src1,
    input  logic [DISP_W*TAG_W-1:0]    disp_src2,
    input  logic [DISP_W-1:0]          disp_rdy1,
    input  logic [DISP_W-1:0]          disp_rdy2,
    input  logic [DISP_W*LAT_W-1:0]    disp_dly1,
    input  logic [DISP_W*LAT_W-1:0]    disp_dly2,
    input  logic [DISP_W*TAG_W-1:0]    disp_dst,
    input  logic [DISP_W*(ROB_W+1)-1:0] disp_rob,
    input  logic [DISP_W*PAY_W-1:0]    disp_pay,
    input  logic [BC_W-1:0]            bc_valid,
    input  logic [BC_W*TAG_W-1:0]      bc_tag,
    input  logic                       prmiss,
    input  logic [ROB_W:0]             prmiss_rob,
    output logic [ISS_W-1:0]           iss_valid,
    output logic [ISS_W*TAG_W-1:0]     iss_src1,
    output logic [ISS_W*TAG_W-1:0]     iss_src2,
    output logic [ISS_W*TAG_W-1:0]     iss_dst,
    output logic [ISS_W*(ROB_W+1)-1:0] iss_rob,
    output logic [ISS_W*PAY_W-1:0]     iss_pay
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]              r_valid;
    logic [ENTRIES-1:0][ENTRIES-1:0] r_old;
    logic [TAG_W-1:0]                r_src [ENTRIES][2];
    logic [LAT_W-1:0]                r_dly [ENTRIES][2];
    logic [LAT_W-1:0]                r_sh  [ENTRIES][2];
    logic [1:0]                      r_m   [ENTRIES];
    logic [TAG_W-1:0]                r_dst [ENTRIES];
    logic [ROB_W:0]                  r_rob [ENTRIES];
    logic [PAY_W-1:0]                r_pay [ENTRIES];

    logic [TAG_W-1:0]          w_dsrc [DISP_W][2];
    logic [LAT_W-1:0]          w_ddly [DISP_W][2];
    logic [1:0]                w_drdy [DISP_W];
    logic [IDX_W-1:0]          w_idx  [DISP_W];
    logic [DISP_W-1:0]         w_alloc;
    logic [ENTRIES-1:0]        w_req;
    logic [ISS_W*ENTRIES-1:0]  w_gnt;
    logic [ISS_W-1:0]          w_any;
    logic [ISS_W*TAG_W-1:0]    w_isrc1, w_isrc2, w_idst;
    logic [ISS_W*(ROB_W+1)-1:0] w_irob;
    logic [ISS_W*PAY_W-1:0]    w_ipay;

    function automatic logic bc_hit(input logic [TAG_W-1:0] t);
        bc_hit = 1'b0;
        for (int b = 0; b < BC_W; b++)
            if (bc_valid[b] && bc_tag[b*TAG_W +: TAG_W] == t) bc_hit = 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < DISP_W; k++) begin
            w_dsrc[k][0] = disp_src1[k*TAG_W +: TAG_W];
            w_dsrc[k][1] = disp_src2[k*TAG_W +: TAG_W];
            w_ddly[k][0] = disp_dly1[k*LAT_W +: LAT_W];
            w_ddly[k][1] = disp_dly2[k*LAT_W +: LAT_W];
            w_drdy[k]    = {disp_rdy2[k], disp_rdy1[k]};
        end
    end

    // slot k takes the free entry whose rank equals the number of valid slots below k
    always_comb begin
        int nf, rank, cnt;
        nf = 0;
        for (int i = 0; i < ENTRIES; i++) nf += int'(!r_valid[i]);
        disp_ready = nf >= DISP_W;
        rank = 0;
        cnt  = 0;
        for (int k = 0; k < DISP_W; k++) begin
            w_alloc[k] = disp_ready & !prmiss & disp_valid[k];
            w_idx[k]   = '0;
            cnt        = 0;
            for (int i = 0; i < ENTRIES; i++)
                if (!r_valid[i]) begin
                    if (cnt == rank) w_idx[k] = IDX_W'(i);
                    cnt++;
                end
            rank += int'(disp_valid[k]);
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) w_req[i] = r_valid[i] & r_sh[i][0][0] & r_sh[i][1][0];
    end

    issue_queue_param_age_select #(.ENTRIES(ENTRIES), .ISS_W(ISS_W)) u_sel (
        .i_old  (r_old),
        .i_req  (w_req),
        .o_grant(w_gnt)
    );

    always_comb begin
        w_any = '0; w_isrc1 = '0; w_isrc2 = '0; w_idst = '0; w_irob = '0; w_ipay = '0;
        for (int p = 0; p < ISS_W; p++)
            for (int i = 0; i < ENTRIES; i++)
                if (w_gnt[p*ENTRIES+i]) begin
                    w_any[p] = 1'b1;
                    w_isrc1[p*TAG_W +: TAG_W]       = r_src[i][0];
                    w_isrc2[p*TAG_W +: TAG_W]       = r_src[i][1];
                    w_idst[p*TAG_W +: TAG_W]        = r_dst[i];
                    w_irob[p*(ROB_W+1) +: ROB_W+1]  = r_rob[i];
                    w_ipay[p*PAY_W +: PAY_W]        = r_pay[i];
                end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= '0;
            r_old     <= '0;
            iss_valid <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_dst   <= '0;
            iss_rob   <= '0;
            iss_pay   <= '0;
        end else begin
            iss_valid <= prmiss ? '0 : w_any;
            iss_src1  <= w_isrc1;
            iss_src2  <= w_isrc2;
            iss_dst   <= w_idst;
            iss_rob   <= w_irob;
            iss_pay   <= w_ipay;
            for (int i = 0; i < ENTRIES; i++) begin
                if (prmiss && r_valid[i] && rob_younger(32'(r_rob[i]), 32'(prmiss_rob), ROB_W))
                    r_valid[i] <= 1'b0;
                for (int p = 0; p < ISS_W; p++)
                    if (!prmiss && w_gnt[p*ENTRIES+i]) r_valid[i] <= 1'b0;
            end
            // a new entry is younger than every valid entry and every lower same-cycle slot
            for (int k = 0; k < DISP_W; k++)
                if (w_alloc[k]) begin
                    r_valid[w_idx[k]] <= 1'b1;
                    for (int j = 0; j < ENTRIES; j++) begin
                        r_old[w_idx[k]][j] <= 1'b0;
                        r_old[j][w_idx[k]] <= r_valid[j];
                    end
                    for (int q = 0; q < k; q++)
                        if (w_alloc[q]) r_old[w_idx[q]][w_idx[k]] <= 1'b1;
                end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++)
            for (int o = 0; o < 2; o++)
                if (!r_sh[i][o][0]) begin
                    if (r_m[i][o]) r_sh[i][o] <= {r_sh[i][o][LAT_W-1], r_sh[i][o][LAT_W-1:1]};
                    else if (bc_hit(r_src[i][o])) begin
                        r_m[i][o]  <= 1'b1;
                        r_sh[i][o] <= r_dly[i][o];
                    end
                end
        // a broadcast in the dispatch cycle is captured here, overriding the wakeup above
        for (int k = 0; k < DISP_W; k++)
            if (w_alloc[k]) begin
                for (int o = 0; o < 2; o++) begin
                    r_src[w_idx[k]][o] <= w_dsrc[k][o];
                    r_dly[w_idx[k]][o] <= w_ddly[k][o];
                    r_m[w_idx[k]][o]   <= w_drdy[k][o] | bc_hit(w_dsrc[k][o]);
                    r_sh[w_idx[k]][o]  <= w_drdy[k][o] ? '1 : bc_hit(w_dsrc[k][o]) ? w_ddly[k][o] : '0;
                end
                r_dst[w_idx[k]] <= disp_dst[k*TAG_W +: TAG_W];
                r_rob[w_idx[k]] <= disp_rob[k*(ROB_W+1) +: ROB_W+1];
                r_pay[w_idx[k]] <= disp_pay[k*PAY_W +: PAY_W];
            end
    end
endmodule

// File: tb/tb_issue_queue_param.sv
// tb_issue_queue_param: directed self-checking bench for issue_queue_param.
module tb_issue_queue_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  disp_valid;
    logic        disp_ready;
    logic [11:0] disp_src1, disp_src2, disp_dst;
    logic [1:0]  disp_rdy1, disp_rdy2;
    logic [7:0]  disp_dly1, disp_dly2;
    logic [13:0] disp_rob;
    logic [63:0] disp_pay;
    logic [1:0]  bc_valid;
    logic [11:0] bc_tag;
    logic        prmiss;
    logic [6:0]  prmiss_rob;
    logic [1:0]  iss_valid;
    logic [11:0] iss_src1, iss_src2, iss_dst;
    logic [13:0] iss_rob;
    logic [63:0] iss_pay;
    int checks = 0;
    int errors = 0;

    issue_queue_param dut (
        .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
        .disp_dly1(disp_dly1), .disp_dly2(disp_dly2), .disp_dst(disp_dst), .disp_rob(disp_rob),
        .disp_pay(disp_pay), .bc_valid(bc_valid), .bc_tag(bc_tag), .prmiss(prmiss),
        .prmiss_rob(prmiss_rob), .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_dst(iss_dst), .iss_rob(iss_rob), .iss_pay(iss_pay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        disp_valid = '0; disp_src1 = '0; disp_src2 = '0; disp_rdy1 = '0; disp_rdy2 = '0;
        disp_dly1 = '0; disp_dly2 = '0; disp_dst = '0; disp_rob = '0; disp_pay = '0;
        bc_valid = '0; bc_tag = '0; prmiss = 1'b0; prmiss_rob = '0;
    endtask

    // src2 is always ready with tag s1+1
    task automatic put(input int s, input logic [5:0] s1, input logic r1, input logic [3:0] d1,
                       input logic [6:0] rob, input logic [5:0] dst, input logic [31:0] pay);
        disp_valid[s]        = 1'b1;
        disp_src1[s*6 +: 6]  = s1;
        disp_rdy1[s]         = r1;
        disp_dly1[s*4 +: 4]  = d1;
        disp_src2[s*6 +: 6]  = s1 + 6'd1;
        disp_rdy2[s]         = 1'b1;
        disp_dly2[s*4 +: 4]  = 4'b1111;
        disp_rob[s*7 +: 7]   = rob;
        disp_dst[s*6 +: 6]   = dst;
        disp_pay[s*32 +: 32] = pay;
    endtask

    task automatic bc(input int s, input logic [5:0] tag);
        bc_valid[s]       = 1'b1;
        bc_tag[s*6 +: 6]  = tag;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick; tick;
        chk("rst_iss_valid", 64'(iss_valid), 64'h0);
        chk("rst_disp_ready", 64'(disp_ready), 64'h1);
        chk("rst_iss_rob", 64'(iss_rob), 64'h0);
        reset = 1'b0;
        tick;
        // two ready instructions, both issue the cycle after allocation
        put(0, 6'd1, 1'b1, 4'b1111, 7'h00, 6'd10, 32'hA0);
        put(1, 6'd3, 1'b1, 4'b1111, 7'h01, 6'd11, 32'hA1);
        tick; idle();
        chk("t1_not_yet", 64'(iss_valid), 64'h0);
        tick;
        chk("t1_valid", 64'(iss_valid), 64'h3);
        chk("t1_rob_p0", 64'(iss_rob[6:0]), 64'h00);
        chk("t1_rob_p1", 64'(iss_rob[13:7]), 64'h01);
        chk("t1_dst_p0", 64'(iss_dst[5:0]), 64'd10);
        chk("t1_src1_p0", 64'(iss_src1[5:0]), 64'd1);
        chk("t1_src2_p1", 64'(iss_src2[11:6]), 64'd4);
        chk("t1_pay_p1", 64'(iss_pay[63:32]), 64'hA1);
        tick;
        chk("t1_drain", 64'(iss_valid), 64'h0);
        // dependent source with two-cycle shift pattern
        put(0, 6'd5, 1'b0, 4'b0100, 7'h02, 6'd12, 32'hB0);
        tick; idle();
        tick;
        chk("t2_no_bc", 64'(iss_valid), 64'h0);
        bc(0, 6'd5);
        tick; idle();
        chk("t2_lat1", 64'(iss_valid), 64'h0);
        tick;
        chk("t2_lat2", 64'(iss_valid), 64'h0);
        tick;
        chk("t2_lat3", 64'(iss_valid), 64'h0);
        tick;
        chk("t2_issue", 64'(iss_valid), 64'h1);
        chk("t2_rob", 64'(iss_rob[6:0]), 64'h02);
        tick;
        chk("t2_drain", 64'(iss_valid), 64'h0);
        // fill all entries with unready instructions
        for (int c = 0; c < 4; c++) begin
            chk("t3_ready_fill", 64'(disp_ready), 64'h1);
            put(0, 6'(20 + 2*c), 1'b0, 4'b1111, 7'(8 + 2*c), 6'd30, 32'hC0);
            put(1, 6'(21 + 2*c), 1'b0, 4'b1111, 7'(9 + 2*c), 6'd31, 32'hC1);
            tick; idle();
        end
        chk("t3_full", 64'(disp_ready), 64'h0);
        put(0, 6'd60, 1'b1, 4'b1111, 7'h28, 6'd1, 32'hDD);
        put(1, 6'd60, 1'b1, 4'b1111, 7'h29, 6'd2, 32'hDE);
        tick; idle();
        chk("t3_full_pending", 64'(disp_ready), 64'h0);
        bc(0, 6'd20); bc(1, 6'd21);
        tick; idle();
        chk("t3_woken_full", 64'(disp_ready), 64'h0);
        chk("t3_woken_noiss", 64'(iss_valid), 64'h0);
        tick;
        chk("t3_issue", 64'(iss_valid), 64'h3);
        chk("t3_rob_p0", 64'(iss_rob[6:0]), 64'h08);
        chk("t3_rob_p1", 64'(iss_rob[13:7]), 64'h09);
        chk("t3_ready_again", 64'(disp_ready), 64'h1);
        reset = 1'b1;
        #1;
        chk("t3_async_rst", 64'(iss_valid), 64'h0);
        tick;
        reset = 1'b0;
        tick;
        // mispredict flush by ROB age with sort-bit wrap
        put(0, 6'd40, 1'b0, 4'b1111, 7'h05, 6'd13, 32'hE0);
        put(1, 6'd40, 1'b0, 4'b1111, 7'h07, 6'd14, 32'hE1);
        tick; idle();
        put(0, 6'd40, 1'b0, 4'b1111, 7'h42, 6'd15, 32'hE2);
        tick; idle();
        prmiss = 1'b1; prmiss_rob = 7'h06;
        put(0, 6'd1, 1'b1, 4'b1111, 7'h03, 6'd16, 32'hE3);
        tick; idle();
        chk("t4_flush_cycle", 64'(iss_valid), 64'h0);
        bc(0, 6'd40);
        tick; idle();
        chk("t4_no_bogus", 64'(iss_valid), 64'h0);
        tick;
        chk("t4_survivor", 64'(iss_valid), 64'h1);
        chk("t4_survivor_rob", 64'(iss_rob[6:0]), 64'h05);
        tick;
        chk("t4_drain", 64'(iss_valid), 64'h0);
        // broadcast in the dispatch cycle, three-cycle latency
        put(0, 6'd9, 1'b0, 4'b1000, 7'h0A, 6'd17, 32'hF0);
        bc(0, 6'd9);
        tick; idle();
        chk("t5_lat0", 64'(iss_valid), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("t5_lat", 64'(iss_valid), 64'h0);
        end
        tick;
        chk("t5_issue", 64'(iss_valid), 64'h1);
        chk("t5_rob", 64'(iss_rob[6:0]), 64'h0A);
        tick;
        // three ready at once, two ports
        put(0, 6'd50, 1'b0, 4'b1111, 7'h10, 6'd18, 32'h10);
        put(1, 6'd50, 1'b0, 4'b1111, 7'h11, 6'd19, 32'h11);
        tick; idle();
        put(0, 6'd50, 1'b0, 4'b1111, 7'h12, 6'd20, 32'h12);
        tick; idle();
        bc(0, 6'd50);
        tick; idle();
        tick;
        chk("t6_first2", 64'(iss_valid), 64'h3);
        chk("t6_rob_p0", 64'(iss_rob[6:0]), 64'h10);
        chk("t6_rob_p1", 64'(iss_rob[13:7]), 64'h11);
        tick;
        chk("t6_third", 64'(iss_valid), 64'h1);
        chk("t6_third_rob", 64'(iss_rob[6:0]), 64'h12);
        tick;
        chk("t6_drain", 64'(iss_valid), 64'h0);
        // reset in the middle of a burst drops the third instruction
        put(0, 6'd50, 1'b0, 4'b1111, 7'h20, 6'd21, 32'h20);
        put(1, 6'd50, 1'b0, 4'b1111, 7'h21, 6'd22, 32'h21);
        tick; idle();
        put(0, 6'd50, 1'b0, 4'b1111, 7'h22, 6'd23, 32'h22);
        tick; idle();
        bc(0, 6'd50);
        tick; idle();
        tick;
        chk("t6b_first2", 64'(iss_valid), 64'h3);
        reset = 1'b1;
        #1;
        chk("t6b_async_clear", 64'(iss_valid), 64'h0);
        tick;
        reset = 1'b0;
        tick;
        chk("t6b_no_third", 64'(iss_valid), 64'h0);
        chk("t6b_ready", 64'(disp_ready), 64'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
